cci_mpf_shim_lockstep_issue: RTL and testbench

- Issue stage directly downstream of the lockstep Tx buffer. Consumes the paired c0/c1 request head and drives the buffer's single deqTx.
- Forwards requests to the FIU-side channels under per-channel almost-full back pressure.
- Splits a pair across cycles when one channel is blocked or when the read and write target the same line. In the same-line case the write always issues before the read.
- Keeps saturating activity counters.

---
 rtl/cci_mpf_shim_lockstep_issue_if.sv | 43 ++++
 rtl/cci_mpf_shim_lockstep_issue.sv | 124 ++++++++++++
 tb/tb_cci_mpf_shim_lockstep_issue.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cci_mpf_shim_lockstep_issue_if.sv
// Bundle between the lockstep Tx buffer head, the FIU-side channels and the issue stage.
// The issue stage uses the slave view; whatever drives the head and back pressure uses master.
interface cci_mpf_shim_lockstep_issue_if #(
    parameter int ADDR_BITS = 42,
    parameter int REQ0_BITS = 80,
    parameter int REQ1_BITS = 600,
    parameter int CNT_BITS  = 32
);
    logic                 head_valid;
    logic                 head_c0_valid;
    logic [ADDR_BITS-1:0] head_c0_addr;
    logic [REQ0_BITS-1:0] head_c0_req;
    logic                 head_c1_valid;
    logic [ADDR_BITS-1:0] head_c1_addr;
    logic [REQ1_BITS-1:0] head_c1_req;
    logic                 deqTx;
    logic                 fiu_c0_almFull;
    logic                 fiu_c1_almFull;
    logic                 fiu_c0_valid;
    logic [REQ0_BITS-1:0] fiu_c0_req;
    logic                 fiu_c1_valid;
    logic [REQ1_BITS-1:0] fiu_c1_req;
    logic                 busy;
    logic [CNT_BITS-1:0]  cnt_pairs;
    logic [CNT_BITS-1:0]  cnt_splits;
    logic [CNT_BITS-1:0]  cnt_stalls;

    modport slave (
        input  head_valid, head_c0_valid, head_c0_addr, head_c0_req,
               head_c1_valid, head_c1_addr, head_c1_req,
               fiu_c0_almFull, fiu_c1_almFull,
        output deqTx, fiu_c0_valid, fiu_c0_req, fiu_c1_valid, fiu_c1_req,
               busy, cnt_pairs, cnt_splits, cnt_stalls
    );

    modport master (
        output head_valid, head_c0_valid, head_c0_addr, head_c0_req,
               head_c1_valid, head_c1_addr, head_c1_req,
               fiu_c0_almFull, fiu_c1_almFull,
        input  deqTx, fiu_c0_valid, fiu_c0_req, fiu_c1_valid, fiu_c1_req,
               busy, cnt_pairs, cnt_splits, cnt_stalls
    );
endinterface

// File: rtl/cci_mpf_shim_lockstep_issue.sv
// Issue stage after the lockstep Tx buffer: forwards the c0/c1 head pair to the FIU,
// splitting it across cycles under back pressure or a same-line read/write conflict.
module cci_mpf_shim_lockstep_issue #(
    parameter int ADDR_BITS = 42,
    parameter int REQ0_BITS = 80,
    parameter int REQ1_BITS = 600,
    parameter int CNT_BITS  = 32
) (
    input logic clk,
    input logic reset,
    cci_mpf_shim_lockstep_issue_if.slave bus
);
    typedef enum logic [1:0] {PAIR, C0_DONE, C1_DONE} state_t;

    state_t state_q, state_d;
    logic   iss0, iss1, deq, split;
    logic   v0, v1, can0, can1, conflict;

    logic                 fiu_c0_valid_q, fiu_c1_valid_q;
    logic [REQ0_BITS-1:0] fiu_c0_req_q;
    logic [REQ1_BITS-1:0] fiu_c1_req_q;
    logic [CNT_BITS-1:0]  cnt_pairs_q, cnt_pairs_d;
    logic [CNT_BITS-1:0]  cnt_splits_q, cnt_splits_d;
    logic [CNT_BITS-1:0]  cnt_stalls_q, cnt_stalls_d;

    assign v0       = bus.head_c0_valid;
    assign v1       = bus.head_c1_valid;
    assign can0     = !v0 || !bus.fiu_c0_almFull;
    assign can1     = !v1 || !bus.fiu_c1_almFull;
    assign conflict = v0 && v1 && (bus.head_c0_addr == bus.head_c1_addr);

    always_comb begin
        state_d = state_q;
        iss0    = 1'b0;
        iss1    = 1'b0;
        deq     = 1'b0;
        split   = 1'b0;
        if (bus.head_valid) begin
            unique case (state_q)
                PAIR: begin
                    if (!v0 && !v1) begin
                        deq = 1'b1;
                    end else if (conflict) begin
                        // Same line: the write goes first, the read follows in a later cycle.
                        if (can1) begin
                            iss1    = 1'b1;
                            split   = 1'b1;
                            state_d = C1_DONE;
                        end
                    end else if (can0 && can1) begin
                        iss0 = v0;
                        iss1 = v1;
                        deq  = 1'b1;
                    end else if (can0 && v0) begin
                        iss0    = 1'b1;
                        state_d = C0_DONE;
                    end else if (can1 && v1) begin
                        iss1    = 1'b1;
                        state_d = C1_DONE;
                    end
                end
                C1_DONE: begin
                    if (!bus.fiu_c0_almFull) begin
                        iss0    = 1'b1;
                        deq     = 1'b1;
                        state_d = PAIR;
                    end
                end
                C0_DONE: begin
                    if (!bus.fiu_c1_almFull) begin
                        iss1    = 1'b1;
                        deq     = 1'b1;
                        state_d = PAIR;
                    end
                end
                default: state_d = PAIR;
            endcase
        end
    end

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c, input logic en);
        return (en && (c != '1)) ? c + CNT_BITS'(1) : c;
    endfunction

    assign cnt_pairs_d  = sat_inc(cnt_pairs_q, deq && (v0 || v1));
    assign cnt_splits_d = sat_inc(cnt_splits_q, split);
    assign cnt_stalls_d = sat_inc(cnt_stalls_q, bus.head_valid && !deq);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= PAIR;
            fiu_c0_valid_q <= 1'b0;
            fiu_c1_valid_q <= 1'b0;
            fiu_c0_req_q   <= '0;
            fiu_c1_req_q   <= '0;
            cnt_pairs_q    <= '0;
            cnt_splits_q   <= '0;
            cnt_stalls_q   <= '0;
        end else begin
            state_q        <= state_d;
            fiu_c0_valid_q <= iss0;
            fiu_c1_valid_q <= iss1;
            if (iss0) fiu_c0_req_q <= bus.head_c0_req;
            if (iss1) fiu_c1_req_q <= bus.head_c1_req;
            cnt_pairs_q    <= cnt_pairs_d;
            cnt_splits_q   <= cnt_splits_d;
            cnt_stalls_q   <= cnt_stalls_d;
        end
    end

    assign bus.deqTx        = deq;
    assign bus.fiu_c0_valid = fiu_c0_valid_q;
    assign bus.fiu_c0_req   = fiu_c0_req_q;
    assign bus.fiu_c1_valid = fiu_c1_valid_q;
    assign bus.fiu_c1_req   = fiu_c1_req_q;
    assign bus.busy         = (state_q != PAIR);
    assign bus.cnt_pairs    = cnt_pairs_q;
    assign bus.cnt_splits   = cnt_splits_q;
    assign bus.cnt_stalls   = cnt_stalls_q;

    // The buffer must keep its head while half of it is still outstanding.
    a_head_held: assert property (@(posedge clk) disable iff (reset)
        (state_q != PAIR) |-> bus.head_valid);
endmodule

// File: tb/tb_cci_mpf_shim_lockstep_issue.sv
// Directed bench for the lockstep issue stage; FIU issues are checked against a scoreboard
// of expected requests tagged with the cycle in which they must appear.
module tb_cci_mpf_shim_lockstep_issue;
    localparam int AB = 42;
    localparam int R0 = 80;
    localparam int R1 = 600;
    localparam int CB = 4;   // narrow counters so saturation is reachable by real stalls

    typedef struct { logic [R0-1:0] req; int cyc; } e0_t;
    typedef struct { logic [R1-1:0] req; int cyc; } e1_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    e0_t  q0[$];
    e1_t  q1[$];

    cci_mpf_shim_lockstep_issue_if #(.ADDR_BITS(AB), .REQ0_BITS(R0), .REQ1_BITS(R1), .CNT_BITS(CB)) bus();

    cci_mpf_shim_lockstep_issue #(.ADDR_BITS(AB), .REQ0_BITS(R0), .REQ1_BITS(R1), .CNT_BITS(CB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [R0-1:0] mk0(input logic [7:0] id);
        return {8'hC0, 56'h0, id, 8'h5A};
    endfunction

    function automatic logic [R1-1:0] mk1(input logic [7:0] id);
        logic [R1-1:0] r;
        r = '0;
        r[R1-1 -: 8] = 8'hC1;
        r[300 +: 8]  = id;
        r[7:0]       = id;
        return r;
    endfunction

    // Expect an issue decided in the current cycle to show up on the FIU one cycle later.
    task automatic exp0(input logic [R0-1:0] r);
        q0.push_back('{req: r, cyc: cyc + 1});
    endtask

    task automatic exp1(input logic [R1-1:0] r);
        q1.push_back('{req: r, cyc: cyc + 1});
    endtask

    task automatic head(input bit a, input logic [AB-1:0] a0, input logic [R0-1:0] r0,
                        input bit b, input logic [AB-1:0] a1, input logic [R1-1:0] r1);
        bus.head_valid    = 1'b1;
        bus.head_c0_valid = a;
        bus.head_c0_addr  = a0;
        bus.head_c0_req   = r0;
        bus.head_c1_valid = b;
        bus.head_c1_addr  = a1;
        bus.head_c1_req   = r1;
    endtask

    task automatic idle();
        bus.head_valid    = 1'b0;
        bus.head_c0_valid = 1'b0;
        bus.head_c1_valid = 1'b0;
    endtask

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    // Monitor: every FIU strobe must match the oldest expected entry, in its cycle.
    always @(negedge clk) begin
        if (bus.fiu_c0_valid === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
                failures++;
                $display("FAIL c0_unexpected: got req %h at cycle %0d expected no c0 issue", bus.fiu_c0_req, cyc);
            end else begin
                e0_t e;
                e = q0.pop_front();
                if (bus.fiu_c0_req !== e.req || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL c0_issue: got req %h cycle %0d expected req %h cycle %0d", bus.fiu_c0_req, cyc, e.req, e.cyc);
                end
            end
        end
        if (bus.fiu_c1_valid === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL c1_unexpected: got req low %h at cycle %0d expected no c1 issue", bus.fiu_c1_req[63:0], cyc);
            end else begin
                e1_t e;
                e = q1.pop_front();
                if (bus.fiu_c1_req !== e.req || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL c1_issue: got req %h cycle %0d expected req %h cycle %0d", bus.fiu_c1_req, cyc, e.req, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        reset              = 1'b1;
        bus.fiu_c0_almFull = 1'b0;
        bus.fiu_c1_almFull = 1'b0;
        bus.head_c0_addr   = '0;
        bus.head_c1_addr   = '0;
        bus.head_c0_req    = '0;
        bus.head_c1_req    = '0;
        idle();
        #1;
        chk("rst_c0_valid", 64'(bus.fiu_c0_valid), 0);
        chk("rst_c1_valid", 64'(bus.fiu_c1_valid), 0);
        chk("rst_busy",     64'(bus.busy), 0);
        chk("rst_pairs",    64'(bus.cnt_pairs), 0);
        chk("rst_stalls",   64'(bus.cnt_stalls), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Non-conflicting pair, no back pressure: both halves in one go.
        next();
        head(1, 42'h10, mk0(8'h01), 1, 42'h20, mk1(8'h02));
        #1 chk("pair_deq", 64'(bus.deqTx), 1);
        exp0(mk0(8'h01)); exp1(mk1(8'h02));
        next(); idle();
        chk("pair_cnt_pairs",  64'(bus.cnt_pairs), 1);
        chk("pair_cnt_splits", 64'(bus.cnt_splits), 0);

        // Same line: write first, read and deq next cycle.
        head(1, 42'h40, mk0(8'h03), 1, 42'h40, mk1(8'h04));
        #1 chk("conf_deq0", 64'(bus.deqTx), 0);
        exp1(mk1(8'h04));
        next();
        chk("conf_busy", 64'(bus.busy), 1);
        chk("conf_deq1", 64'(bus.deqTx), 1);
        exp0(mk0(8'h03));
        next(); idle();
        chk("conf_splits", 64'(bus.cnt_splits), 1);
        chk("conf_stalls", 64'(bus.cnt_stalls), 1);
        chk("conf_pairs",  64'(bus.cnt_pairs), 2);

        // c0 back pressure for 3 cycles: c1 goes at once, c0 on the 4th cycle.
        bus.fiu_c0_almFull = 1'b1;
        head(1, 42'h11, mk0(8'h05), 1, 42'h22, mk1(8'h06));
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp0_nodeq", 64'(bus.deqTx), 0);
            if (i == 0) exp1(mk1(8'h06));
            next();
        end
        bus.fiu_c0_almFull = 1'b0;
        #1 chk("bp0_deq", 64'(bus.deqTx), 1);
        exp0(mk0(8'h05));
        next(); idle();
        chk("bp0_stalls", 64'(bus.cnt_stalls), 4);
        chk("bp0_pairs",  64'(bus.cnt_pairs), 3);

        // Single-half heads back to back; same address is not a conflict.
        head(0, 42'h30, mk0(8'hEE), 1, 42'h30, mk1(8'h07));
        #1 chk("c1only_deq", 64'(bus.deqTx), 1);
        exp1(mk1(8'h07));
        next();
        head(1, 42'h30, mk0(8'h08), 0, 42'h30, mk1(8'hEE));
        #1 chk("c0only_deq", 64'(bus.deqTx), 1);
        exp0(mk0(8'h08));
        next();
        // Empty head: popped, counted nowhere.
        head(0, 42'h0, mk0(8'hEE), 0, 42'h0, mk1(8'hEE));
        #1 chk("empty_deq", 64'(bus.deqTx), 1);
        next(); idle();
        chk("single_pairs",  64'(bus.cnt_pairs), 5);
        chk("single_stalls", 64'(bus.cnt_stalls), 4);

        // c1 back pressure one cycle: c0 goes first, c1 completes the pair.
        bus.fiu_c1_almFull = 1'b1;
        head(1, 42'h50, mk0(8'h09), 1, 42'h60, mk1(8'h0A));
        #1 chk("bp1_nodeq", 64'(bus.deqTx), 0);
        exp0(mk0(8'h09));
        next();
        bus.fiu_c1_almFull = 1'b0;
        chk("bp1_busy", 64'(bus.busy), 1);
        #1 chk("bp1_deq", 64'(bus.deqTx), 1);
        exp1(mk1(8'h0A));
        next(); idle();
        chk("bp1_stalls", 64'(bus.cnt_stalls), 5);

        // Conflict with c1 blocked: nothing at all issues, even though c0 could.
        bus.fiu_c1_almFull = 1'b1;
        head(1, 42'h70, mk0(8'h0B), 1, 42'h70, mk1(8'h0C));
        #1 chk("confbp_nodeq", 64'(bus.deqTx), 0);
        next();
        chk("confbp_busy", 64'(bus.busy), 0);
        bus.fiu_c1_almFull = 1'b0;
        #1 chk("confbp_nodeq2", 64'(bus.deqTx), 0);
        exp1(mk1(8'h0C));
        next();
        chk("confbp_deq", 64'(bus.deqTx), 1);
        exp0(mk0(8'h0B));
        next(); idle();
        chk("confbp_stalls", 64'(bus.cnt_stalls), 7);
        chk("confbp_splits", 64'(bus.cnt_splits), 2);
        chk("confbp_pairs",  64'(bus.cnt_pairs), 7);

        // Reset while waiting in C1_DONE abandons the read half.
        head(1, 42'h80, mk0(8'h0D), 1, 42'h80, mk1(8'h0E));
        exp1(mk1(8'h0E));
        next();
        bus.fiu_c0_almFull = 1'b1;
        #1 chk("mid_busy", 64'(bus.busy), 1);
        chk("mid_c1_valid", 64'(bus.fiu_c1_valid), 1);
        #1;
        reset = 1'b1;
        idle();
        bus.fiu_c0_almFull = 1'b0;
        #1;
        chk("arst_c1_valid",  64'(bus.fiu_c1_valid), 0);
        chk("arst_c1_req",    64'(|bus.fiu_c1_req), 0);
        chk("arst_c0_req",    64'(|bus.fiu_c0_req), 0);
        chk("arst_busy",      64'(bus.busy), 0);
        chk("arst_pairs",     64'(bus.cnt_pairs), 0);
        chk("arst_splits",    64'(bus.cnt_splits), 0);
        chk("arst_stalls",    64'(bus.cnt_stalls), 0);
        next();
        reset = 1'b0;
        next();
        head(1, 42'h90, mk0(8'h0F), 1, 42'hA0, mk1(8'h10));
        #1 chk("post_rst_deq", 64'(bus.deqTx), 1);
        exp0(mk0(8'h0F)); exp1(mk1(8'h10));
        next(); idle();
        chk("post_rst_pairs", 64'(bus.cnt_pairs), 1);

        // Stall counter saturation: both channels blocked on a non-conflicting pair.
        bus.fiu_c0_almFull = 1'b1;
        bus.fiu_c1_almFull = 1'b1;
        head(1, 42'h91, mk0(8'h11), 1, 42'hA1, mk1(8'h12));
        repeat (14) next();
        chk("sat_near", 64'(bus.cnt_stalls), 64'((1 << CB) - 2));
        repeat (3) next();
        chk("sat_hold", 64'(bus.cnt_stalls), 64'((1 << CB) - 1));
        chk("sat_busy", 64'(bus.busy), 0);
        bus.fiu_c0_almFull = 1'b0;
        bus.fiu_c1_almFull = 1'b0;
        #1 chk("sat_deq", 64'(bus.deqTx), 1);
        exp0(mk0(8'h11)); exp1(mk1(8'h12));
        next(); idle();
        chk("sat_pairs", 64'(bus.cnt_pairs), 2);
        chk("sat_stalls_after", 64'(bus.cnt_stalls), 64'((1 << CB) - 1));

        repeat (2) next();
        chk("q0_drained", 64'(q0.size()), 0);
        chk("q1_drained", 64'(q1.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
